// File: rtl/mode_event_timer.sv
// Mode-gated countdown timer with optional prescaler, pause/hold and auto-reload.
// Outputs come straight from the state/count/strobe registers.
module mode_event_timer #(
  parameter int CNT_WIDTH   = 32,
  parameter int MODE_WIDTH  = 3,
  parameter int ARM_MODE    = 0,
  parameter int TICK_DIV    = 1,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic                  start,
  input  logic                  pause,
  input  logic [CNT_WIDTH-1:0]  load_value,
  output logic [CNT_WIDTH-1:0]  remaining,
  output logic                  running,
  output logic                  done,
  output logic                  expired_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MODE_WIDTH-1:0] ARM_ENC   = MODE_WIDTH'(ARM_MODE);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t                state_reg;
  logic [CNT_WIDTH-1:0]  count_reg;
  logic [PW-1:0]         presc_reg;
  logic                  pulse_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      count_reg <= '0;
      presc_reg <= '0;
      pulse_reg <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      if (current_mode != ARM_ENC) begin
        state_reg <= IDLE;
        count_reg <= '0;
        presc_reg <= '0;
      end else if (start) begin
        count_reg <= load_value;
        presc_reg <= '0;
        if (load_value == '0) begin
          state_reg <= DONE;
          pulse_reg <= 1'b1;
        end else begin
          state_reg <= RUN;
        end
      end else begin
        case (state_reg)
          RUN, HOLD: begin
            if (pause) begin
              state_reg <= HOLD;
            end else begin
              // Leaving HOLD ticks on the same edge, so only pause-high edges are lost.
              state_reg <= RUN;
              if (presc_reg == PRESC_MAX) begin
                presc_reg <= '0;
                if (count_reg == CNT_ONE) begin
                  pulse_reg <= 1'b1;
                  if (AUTO_RELOAD != 0) begin
                    count_reg <= load_value;
                    if (load_value == '0) state_reg <= DONE;
                  end else begin
                    count_reg <= '0;
                    state_reg <= DONE;
                  end
                end else if (count_reg != '0) begin
                  count_reg <= count_reg - CNT_ONE;
                end
              end else begin
                presc_reg <= presc_reg + PW'(1);
              end
            end
          end
          default: begin
            state_reg <= state_reg;
          end
        endcase
      end
    end
  end

  assign remaining     = count_reg;
  assign running       = (state_reg == RUN);
  assign done          = (state_reg == DONE);
  assign expired_pulse = pulse_reg;

endmodule

// File: doc/mode_event_timer.md
MODE_EVENT_TIMER -- requirements
Module: mode_event_timer

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 32: width of the load value and the remaining-time count.
REQ-002 The block SHALL have parameter MODE_WIDTH, default 3: width of the current_mode input.
REQ-003 The block SHALL have parameter ARM_MODE, default 0: the mode encoding in which the timer may run.
REQ-004 The block SHALL have parameter TICK_DIV, default 1: number of clk cycles per count decrement; legal range is 1 or more.
REQ-005 The block SHALL have parameter AUTO_RELOAD, default 0: 1 selects periodic operation, 0 selects one-shot operation.
REQ-006 The block SHALL have input clk, 1 bit: rising-edge clock.
REQ-007 The block SHALL have input rstn, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have input current_mode, MODE_WIDTH bits: the hood's present operating mode.
REQ-009 The block SHALL have input start, 1 bit: level sampled each cycle; loads load_value and starts or restarts the timer.
REQ-010 The block SHALL have input pause, 1 bit: level; freezes the count while high.
REQ-011 The block SHALL have input load_value, CNT_WIDTH bits: the count to load; sampled only on the edge where start is accepted, and on each auto-reload.
REQ-012 The block SHALL have output remaining, CNT_WIDTH bits: the registered count value.
REQ-013 The block SHALL have output running, 1 bit: high when the state is RUN.
REQ-014 The block SHALL have output done, 1 bit: high when the state is DONE.
REQ-015 The block SHALL have output expired_pulse, 1 bit: registered, one-cycle strobe on each expiry.

Function
REQ-016 The block SHALL implement exactly four states:
- IDLE, RUN, HOLD, DONE.
- It SHALL also hold a CNT_WIDTH count register and a prescaler of clog2(TICK_DIV), minimum 1 bit.
REQ-017 Mode gate: on any edge where current_mode != ARM_MODE, the block SHALL:
- set state to IDLE, count to 0 and prescaler to 0;
- hold expired_pulse at 0.
- This gate SHALL take priority over start, pause and expiry.
REQ-018 Start: with the mode matching and start=1 in any state, the block SHALL on that edge:
- load count from load_value and clear the prescaler;
- enter RUN, or enter DONE when load_value==0.
- Start SHALL take priority over pause and over expiry.
REQ-019 A start with load_value==0 SHALL assert expired_pulse for the one cycle that follows.
REQ-020 In RUN, with no start and pause=0:
- if prescaler==TICK_DIV-1, the block SHALL clear the prescaler and decrement the count;
- otherwise it SHALL increment the prescaler.
REQ-021 Expiry: on a decrement edge where count==1, with AUTO_RELOAD=0, the block SHALL set count to 0, enter DONE and assert expired_pulse for exactly the one following cycle.
REQ-022 Expiry with AUTO_RELOAD=1 SHALL instead:
- reload count from load_value and stay in RUN;
- still pulse expired_pulse.
- A reloaded load_value of 0 SHALL enter DONE.
REQ-023 Pause: pause=1 in RUN SHALL move to HOLD with count and prescaler frozen; pause=0 in HOLD SHALL return to RUN and resume counting from the frozen prescaler value.
REQ-024 pause SHALL be ignored in IDLE and DONE.
REQ-025 DONE SHALL be held, with remaining=0, until start or a mode mismatch.
REQ-026 The count SHALL never wrap below 0; it SHALL be decremented only while nonzero.
REQ-027 Latency: with TICK_DIV=1, a start accepted on edge k with load_value=N (N>0) SHALL:
- show remaining=N after edge k;
- reach remaining=0 and DONE at edge k+N;
- assert expired_pulse during cycle k+N to k+N+1.
REQ-028 With TICK_DIV=D, expiry SHALL occur at edge k+N*D, excluding paused cycles.
REQ-029 All outputs SHALL be driven directly from registers or from state decode, with no combinational path from any input.

Reset
REQ-030 While rstn=0, the block SHALL force state=IDLE, count=0, prescaler=0, remaining=0, running=0, done=0 and expired_pulse=0, independent of clk.
REQ-031 After rstn deasserts, the block SHALL remain in IDLE until a start is accepted with the mode matching.
REQ-032 Reset asserted mid-count SHALL discard the count; no expired_pulse SHALL be produced.

Verification
REQ-033 Basic one-shot, TICK_DIV=1, ARM_MODE=0: mode=0, load_value=3, start for 1 cycle -> remaining 3,2,1,0 on successive edges; done=1 and a single expired_pulse at the edge where remaining reaches 0.
REQ-034 Prescale and pause, TICK_DIV=4, load_value=2: pause high for 5 cycles mid-count -> expiry 8+5 cycles after start; remaining unchanged while running=0.
REQ-035 Mode abort: during RUN with remaining=5, current_mode changes to 2 -> next edge IDLE, remaining=0, no expired_pulse; returning to mode 0 without a start -> stays IDLE.
REQ-036 Restart and zero load: start again at remaining=2 with load_value=7 -> remaining=7 and no pulse; start with load_value=0 -> DONE next edge plus one expired_pulse.
REQ-037 Auto-reload, AUTO_RELOAD=1, load_value=2, TICK_DIV=1 -> expired_pulse every 2 cycles; done never asserts; running stays 1.
REQ-038 Async reset: rstn low between clock edges while remaining=4 -> all outputs 0 immediately; no pulse after release.
